// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// lc3_fetch_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : fetch sequencer states
//   PCMUX_*       : PC source selects, shared with the PC register and the
//                   control FSM (this block only ever drives PCMUX_INC)
// -----------------------------------------------------------------------------
package lc3_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DRAIN = 3'd2,
    LATCH = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

endpackage : lc3_fetch_pkg

// File: rtl/instr_fetch_unit_wait_counter.sv
// -----------------------------------------------------------------------------
// fetch_wait_counter
// Counts cycles that memory leaves an access unacknowledged.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous clear (new access starting), wins over enable
//   enable : count one waiting cycle
//   count  : current wait count, saturates at MAX_WAIT
//   tc     : terminal count, high while count == MAX_WAIT
// -----------------------------------------------------------------------------
module fetch_wait_counter #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  output logic [WAIT_W-1:0] count,
  output logic              tc
);

  localparam logic [WAIT_W-1:0] TC_VALUE = WAIT_W'(MAX_WAIT);

  assign tc = (count == TC_VALUE);

  // Wait counter: clear on a new access, otherwise count up and hold at terminal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {WAIT_W{1'b0}};
    end else if (clear) begin
      count <= {WAIT_W{1'b0}};
    end else if (enable && !tc) begin
      count <= count + WAIT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule : fetch_wait_counter

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch sequencer upstream of the PC register: captures PC_IN on Start, runs a
// req/ack read, latches the returned word into IR_OUT and strobes LD_PC with
// the increment select. Supports flush (redirect) and a wait-state timeout.
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   Start, Flush          : fetch request pulse / abort current fetch
//   PC_IN                 : current PC
//   MEM_ACK, MEM_RDATA    : memory response
//   MEM_REQ, MEM_ADDR     : memory request and address
//   IR_OUT                : instruction register
//   LD_PC, PCMUX          : PC load strobe and source select
//   Fetch_Done            : one-cycle pulse, IR_OUT holds new instruction
//   Busy, Fetch_Err       : activity flag / sticky timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import lc3_fetch_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Flush,
  input  logic [DATA_W-1:0] PC_IN,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_REQ,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] IR_OUT,
  output logic              LD_PC,
  output logic [1:0]        PCMUX,
  output logic              Fetch_Done,
  output logic              Busy,
  output logic              Fetch_Err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  fetch_state_t      state;
  fetch_state_t      next_state;
  logic              accept;
  logic              ir_load;
  logic              timeout;
  logic              wait_en;
  logic              wait_tc;
  logic [WAIT_W-1:0] wait_count;

  // Only unacknowledged cycles of an outstanding request count toward timeout
  assign wait_en = ((state == REQ) || (state == DRAIN)) && !MEM_ACK;

  fetch_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_counter (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .clear  (accept),
    .enable (wait_en),
    .count  (wait_count),
    .tc     (wait_tc)
  );

  // Next-state logic and per-cycle register controls
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    ir_load    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (Start) begin
          accept     = 1'b1;
          next_state = REQ;
        end else begin
          next_state = state;
        end
      end
      REQ: begin
        if (MEM_ACK) begin
          if (Flush) begin
            next_state = IDLE;
          end else begin
            ir_load    = 1'b1;
            next_state = LATCH;
          end
        end else if (wait_tc) begin
          // Timeout wins over a simultaneous flush: the access is dead anyway
          timeout    = 1'b1;
          next_state = ERR;
        end else if (Flush) begin
          next_state = DRAIN;
        end else begin
          next_state = REQ;
        end
      end
      DRAIN: begin
        // The outstanding request must still be acknowledged before reuse
        if (MEM_ACK) begin
          next_state = IDLE;
        end else if (wait_tc) begin
          timeout    = 1'b1;
          next_state = ERR;
        end else begin
          next_state = DRAIN;
        end
      end
      LATCH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Address, instruction and sticky error registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      MEM_ADDR  <= {DATA_W{1'b0}};
      IR_OUT    <= {DATA_W{1'b0}};
      Fetch_Err <= 1'b0;
    end else begin
      if (accept) begin
        MEM_ADDR <= PC_IN;
      end
      if (ir_load) begin
        IR_OUT <= MEM_RDATA;
      end
      if (accept) begin
        Fetch_Err <= 1'b0;
      end else if (timeout) begin
        Fetch_Err <= 1'b1;
      end
    end
  end

  // Strobes registered from next state so they track the state register
  // exactly while having no combinational path from any input
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      MEM_REQ    <= 1'b0;
      LD_PC      <= 1'b0;
      Fetch_Done <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      MEM_REQ    <= (next_state == REQ) || (next_state == DRAIN);
      LD_PC      <= (next_state == LATCH);
      Fetch_Done <= (next_state == LATCH);
      Busy       <= (next_state == REQ) || (next_state == DRAIN) ||
                    (next_state == LATCH);
    end
  end

  assign PCMUX = PCMUX_INC;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed stimulus with a scoreboard: each fetch expected to complete pushes
// its expected instruction/address; a monitor pops on every Fetch_Done.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Flush;
  logic [15:0] PC_IN;
  logic        MEM_ACK;
  logic [15:0] MEM_RDATA;
  logic        MEM_REQ;
  logic [15:0] MEM_ADDR;
  logic [15:0] IR_OUT;
  logic        LD_PC;
  logic [1:0]  PCMUX;
  logic        Fetch_Done;
  logic        Busy;
  logic        Fetch_Err;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  instr_fetch_unit #(
    .DATA_W   (16),
    .MAX_WAIT (15)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Flush      (Flush),
    .PC_IN      (PC_IN),
    .MEM_ACK    (MEM_ACK),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_REQ    (MEM_REQ),
    .MEM_ADDR   (MEM_ADDR),
    .IR_OUT     (IR_OUT),
    .LD_PC      (LD_PC),
    .PCMUX      (PCMUX),
    .Fetch_Done (Fetch_Done),
    .Busy       (Busy),
    .Fetch_Err  (Fetch_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && Fetch_Done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_fetch_done: got IR %h expected no pulse", IR_OUT);
      end else begin
        e = exp_q.pop_front();
        check("mon_ir", 32'(IR_OUT), 32'(e.ir));
        check("mon_addr", 32'(MEM_ADDR), 32'(e.addr));
        check("mon_ld_pc", 32'(LD_PC), 32'd1);
        check("mon_pcmux", 32'(PCMUX), 32'd0);
      end
    end
  end

  // Full fetch with `waits` unacknowledged cycles; optional ignored Start
  task automatic fetch(input logic [15:0] pc, input logic [15:0] data,
                       input int waits, input bit poke_start);
    exp_q.push_back('{ir: data, addr: pc});
    PC_IN = pc;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check("wait_req", 32'(MEM_REQ), 32'd1);
      check("wait_addr", 32'(MEM_ADDR), 32'(pc));
      check("wait_no_done", 32'(Fetch_Done), 32'd0);
      if (poke_start && i == 1) begin
        Start = 1'b1;
        PC_IN = pc + 16'h0010;
      end
      tick();
      Start = 1'b0;
      PC_IN = pc;
    end
    check("ack_req", 32'(MEM_REQ), 32'd1);
    check("ack_addr", 32'(MEM_ADDR), 32'(pc));
    MEM_ACK   = 1'b1;
    MEM_RDATA = data;
    tick();
    MEM_ACK   = 1'b0;
    MEM_RDATA = 16'h0000;
    check("latch_done", 32'(Fetch_Done), 32'd1);
    check("latch_ld_pc", 32'(LD_PC), 32'd1);
    check("latch_req_low", 32'(MEM_REQ), 32'd0);
    tick();
    check("post_done_low", {30'd0, Fetch_Done, LD_PC}, 32'd0);
    check("post_busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset_n   = 1'b0;
    Start     = 1'b0;
    Flush     = 1'b0;
    PC_IN     = 16'h0000;
    MEM_ACK   = 1'b0;
    MEM_RDATA = 16'h0000;
    #12;
    check("rst_ir", 32'(IR_OUT), 32'h0);
    check("rst_addr", 32'(MEM_ADDR), 32'h0);
    check("rst_flags", {26'd0, MEM_REQ, LD_PC, Fetch_Done, Busy, Fetch_Err, 1'b0}, 32'd0);
    check("rst_pcmux", 32'(PCMUX), 32'd0);
    Reset_n = 1'b1;

    // Idle: nothing moves without Start
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outputs", {27'd0, MEM_REQ, LD_PC, Fetch_Done, Busy, Fetch_Err}, 32'd0);
      check("idle_ir", 32'(IR_OUT), 32'h0);
    end

    // Zero-wait fetch then back-to-back fetch
    fetch(16'h3000, 16'h1234, 0, 1'b0);
    fetch(16'h3001, 16'h2345, 0, 1'b0);

    // Four wait states, Start while busy dropped
    fetch(16'h3002, 16'hABCD, 4, 1'b1);
    check("ignored_start_idle", 32'(Busy), 32'd0);

    // Flush in second REQ cycle, ACK two cycles later
    PC_IN = 16'h3100;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("fl_req1", 32'(MEM_REQ), 32'd1);
    tick();
    Flush = 1'b1;
    check("fl_req2", 32'(MEM_REQ), 32'd1);
    tick();
    Flush = 1'b0;
    check("fl_drain_req", 32'(MEM_REQ), 32'd1);
    check("fl_drain_addr", 32'(MEM_ADDR), 32'h3100);
    check("fl_drain_busy", 32'(Busy), 32'd1);
    tick();
    MEM_ACK   = 1'b1;
    MEM_RDATA = 16'hDEAD;
    check("fl_drain2_req", 32'(MEM_REQ), 32'd1);
    tick();
    MEM_ACK = 1'b0;
    check("fl_busy_low", 32'(Busy), 32'd0);
    check("fl_no_ld", {30'd0, LD_PC, Fetch_Done}, 32'd0);
    check("fl_ir_kept", 32'(IR_OUT), 32'hABCD);
    fetch(16'h3200, 16'h5678, 0, 1'b0);

    // Timeout: request held 16 cycles (15 tolerated low cycles + timeout cycle)
    PC_IN = 16'h4000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check("to_req_high", 32'(MEM_REQ), 32'd1);
      check("to_err_low", 32'(Fetch_Err), 32'd0);
      tick();
    end
    check("to_req_dropped", 32'(MEM_REQ), 32'd0);
    check("to_err_set", 32'(Fetch_Err), 32'd1);
    check("to_busy_low", 32'(Busy), 32'd0);
    check("to_ir_kept", 32'(IR_OUT), 32'h5678);
    tick();
    check("to_err_sticky", 32'(Fetch_Err), 32'd1);
    exp_q.push_back('{ir: 16'h5A5A, addr: 16'h5000});
    PC_IN = 16'h5000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("err_restart_clr", 32'(Fetch_Err), 32'd0);
    check("err_restart_req", 32'(MEM_REQ), 32'd1);
    check("err_restart_addr", 32'(MEM_ADDR), 32'h5000);
    MEM_ACK   = 1'b1;
    MEM_RDATA = 16'h5A5A;
    tick();
    MEM_ACK = 1'b0;
    check("err_restart_done", 32'(Fetch_Done), 32'd1);
    tick();

    // Async reset in the middle of REQ
    PC_IN = 16'h6000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("ar_req", 32'(MEM_REQ), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("ar_req_drop", 32'(MEM_REQ), 32'd0);
    check("ar_busy_drop", 32'(Busy), 32'd0);
    MEM_ACK   = 1'b1;
    MEM_RDATA = 16'hBEEF;
    tick();
    Reset_n = 1'b1;
    tick();
    tick();
    check("ar_stale_ir", 32'(IR_OUT), 32'h0);
    check("ar_stale_strobes", {29'd0, MEM_REQ, LD_PC, Fetch_Done}, 32'd0);
    MEM_ACK = 1'b0;
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_instr_fetch_unit

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch sequencer that sits directly upstream of the program counter register. On a fetch request from the control FSM it captures the current PC, runs a request/acknowledge read against instruction memory, and latches the returned word into the instruction register. It then commands the PC to increment by asserting load with PC-mux select "increment". Flush support (branch redirect) and a wait-state timeout are included.

## Interface
- DATA_W, 16, width of PC, memory address, memory data and IR
- MAX_WAIT, 15, maximum cycles MEM_ACK may stay low in one access before timeout (≥1)
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- Start  in  1  fetch request pulse from control FSM; sampled only in IDLE
- Flush  in  1  abort current fetch (redirect); effective in REQ only
- PC_IN  in  DATA_W  current PC from program counter output
- MEM_ACK  in  1  memory read data valid for the current request
- MEM_RDATA  in  DATA_W  memory read data, valid when MEM_ACK=1
- MEM_REQ  out  1  read request, held high until MEM_ACK
- MEM_ADDR  out  DATA_W  read address, stable while MEM_REQ=1
- IR_OUT  out  DATA_W  instruction register
- LD_PC  out  1  PC load strobe
- PCMUX  out  2  PC source select; always 2'b00 (increment) from this block
- Fetch_Done  out  1  one-cycle pulse: IR_OUT holds the new instruction
- Busy  out  1  high in every state except IDLE and ERR
- Fetch_Err  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, DRAIN, LATCH, ERR.
- IDLE: Start=1 → capture PC_IN into the address register, clear the wait counter, clear Fetch_Err, go to REQ. Flush is ignored.
- REQ: MEM_REQ=1, MEM_ADDR=captured address.
  - MEM_ACK=1 and Flush=0 → IR_OUT←MEM_RDATA, go to LATCH.
  - MEM_ACK=1 and Flush=1 → discard data, go to IDLE.
  - MEM_ACK=0 and Flush=1 → go to DRAIN.
  - MEM_ACK=0 and Flush=0 → increment the wait counter.
- DRAIN: MEM_REQ stays 1 with the same address. MEM_ACK=1 → discard data, go to IDLE. Start and Flush are ignored.
- LATCH: LD_PC=1, PCMUX=2'b00, Fetch_Done=1 for exactly one cycle, then go to IDLE. Flush is ignored because the instruction is already committed.
- Timeout: in REQ or DRAIN, if the wait counter reaches MAX_WAIT with MEM_ACK=0 → go to ERR, set Fetch_Err=1, drop MEM_REQ. IR_OUT is unchanged.
- ERR: all strobes low. Start=1 → behaves as from IDLE (clears Fetch_Err, goes to REQ).
- IR_OUT changes only on the transition from REQ to LATCH.
- Start while Busy is dropped; it is not queued.

## Timing
- Reset (async assert, sync release): state=IDLE. IR_OUT=16'h0000, MEM_ADDR=16'h0000. MEM_REQ, LD_PC, Fetch_Done, Busy and Fetch_Err are 0. PCMUX=2'b00.
- Reset asserted mid-access: MEM_REQ drops immediately. The pending MEM_ACK after release is ignored because the unit is in IDLE.
- Start sampled at edge 0 → MEM_REQ high in cycle 1.
- ACK in the first REQ cycle → LATCH in cycle 2 (Fetch_Done, LD_PC) → new PC visible and IDLE in cycle 3.
- Latency from Start to Fetch_Done = 2 + W cycles, where W = number of cycles MEM_ACK stays low.
- Back-to-back: Start asserted in cycle 3 is accepted, giving one fetch per 3 cycles at zero wait states.
- Outputs MEM_REQ, LD_PC, Fetch_Done and Busy decode from state only. No input-to-output combinational path.
- Wait counter width is $clog2(MAX_WAIT+1); it saturates and never wraps.

## Structure
- Package lc3_fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, DRAIN, LATCH, ERR)
  - PCMUX_INC=2'b00, PCMUX_BUS=2'b01, PCMUX_ADDER=2'b10, shared with the PC and control FSM
- Sub-module fetch_wait_counter: clear, enable, terminal-count flag at MAX_WAIT, async active-low reset.
- Top: state register, address register, IR register, output decode.

## Test plan
- Reset then idle: no Start for 10 cycles → all outputs 0, IR_OUT=16'h0000, MEM_REQ never rises.
- Zero-wait fetch: PC_IN=16'h3000, Start; memory ACKs immediately with 16'h1234 → MEM_ADDR=16'h3000 in cycle 1, IR_OUT=16'h1234 and LD_PC/Fetch_Done in cycle 2 only, PCMUX=00.
- Wait states: ACK after 4 low cycles with 16'hABCD → Fetch_Done in cycle 6, MEM_ADDR stable throughout, a Start during Busy is ignored.
- Flush: Flush in the 2nd REQ cycle, ACK 2 cycles later with 16'hDEAD → no LD_PC, no Fetch_Done, IR_OUT unchanged, Busy low after the ACK; a following Start fetches normally.
- Timeout: MAX_WAIT=15, never ACK → MEM_REQ drops and Fetch_Err=1 after 15 waiting cycles; next Start clears Fetch_Err and reissues the request.
- Async reset mid-REQ: deassert Reset_n between edges → MEM_REQ low immediately; after release, a stale ACK causes no IR or PC update.
